// File: rtl/j1_loader_pkg.sv
// Shared types and constants for the j1 boot loader.
// The J1_LOADER_CSUM_EN build uses CSUM_W for its running-sum accumulator.
package j1_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DAT_LO = 3'd3,
    ST_DAT_HI = 3'd4,
    ST_CSUM   = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int         CSUM_W    = 8;

endpackage

// File: rtl/j1_loader.sv
// Boot loader: receives a framed image over a byte stream, writes 16-bit words to code RAM,
// then releases the j1 core from reset. Define J1_LOADER_CSUM_EN to expect and verify a checksum byte.
module j1_loader
  import j1_loader_pkg::*;
#(
  parameter int         AW    = 12,
  parameter logic [7:0] MAGIC = MAGIC_DEF
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reload,
  output logic          code_wr,
  output logic [AW-1:0] code_waddr,
  output logic [15:0]   code_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          err,
  output state_t        dbg_state
);

  // Byte stream handshake: a byte moves only on a cycle where in_valid and in_ready are both high;
  // in_data is don't-care otherwise, and in_ready never depends on in_valid.

`ifdef J1_LOADER_CSUM_EN
  localparam state_t S_END = ST_CSUM;
`else
  localparam state_t S_END = ST_RUN;
`endif

  state_t        r_state;
  state_t        w_state_n;
  logic [7:0]    r_len_lo;
  logic [7:0]    r_lo;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_addr;
  logic          w_take;
  logic [15:0]   w_len_n;
  logic          w_oversize;
  logic          w_len_zero;
  logic          w_last_word;
`ifdef J1_LOADER_CSUM_EN
  logic [CSUM_W-1:0] r_csum;
  logic [CSUM_W-1:0] w_csum_sum;
`endif

  assign in_ready    = (r_state != ST_RUN);
  assign w_take      = in_valid & in_ready;
  assign w_len_n     = {in_data, r_len_lo};
  assign w_oversize  = (32'(w_len_n) > (32'd1 << AW));
  assign w_len_zero  = (w_len_n == 16'd0);
  assign w_last_word = (r_cnt == (AW+1)'(1));
`ifdef J1_LOADER_CSUM_EN
  assign w_csum_sum  = r_csum + in_data;
`endif

  assign cpu_reset = (r_state != ST_RUN);
  assign err       = (r_state == ST_ERR);
  assign busy      = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                     (r_state == ST_DAT_LO) || (r_state == ST_DAT_HI) ||
                     (r_state == ST_CSUM);
  assign dbg_state = r_state;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE, ST_ERR: if (w_take && in_data == MAGIC) w_state_n = ST_LEN_LO;
      ST_LEN_LO:       if (w_take) w_state_n = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_take) begin
          if (w_oversize)      w_state_n = ST_ERR;
          else if (w_len_zero) w_state_n = S_END;
          else                 w_state_n = ST_DAT_LO;
        end
      end
      ST_DAT_LO:       if (w_take) w_state_n = ST_DAT_HI;
      ST_DAT_HI:       if (w_take) w_state_n = w_last_word ? S_END : ST_DAT_LO;
`ifdef J1_LOADER_CSUM_EN
      ST_CSUM:         if (w_take) w_state_n = (w_csum_sum == '0) ? ST_RUN : ST_ERR;
`endif
      ST_RUN:          if (reload) w_state_n = ST_IDLE;
      default:         w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_state <= ST_IDLE;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_len_lo   <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      code_wr    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= '0;
    end else begin
      code_wr <= 1'b0;
      if (w_take) begin
        case (r_state)
          ST_LEN_LO: r_len_lo <= in_data;
          ST_LEN_HI: begin
            r_cnt  <= w_len_n[AW:0];
            r_addr <= '0;
          end
          ST_DAT_LO: r_lo <= in_data;
          ST_DAT_HI: begin
            code_wr    <= 1'b1;
            code_waddr <= r_addr;
            code_wdata <= {in_data, r_lo};
            r_addr     <= r_addr + 1'b1;
            r_cnt      <= r_cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef J1_LOADER_CSUM_EN
  // MAGIC is not part of the sum; the accumulator restarts whenever a frame could begin.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_csum <= '0;
    end else if (w_take) begin
      if (r_state == ST_IDLE || r_state == ST_ERR) r_csum <= '0;
      else                                         r_csum <= w_csum_sum;
    end
  end
`endif

endmodule

// File: tb/tb_j1_loader.sv
// Directed bench for j1_loader: a per-cycle vector table plus hand sequences for async reset
// mid-frame and a maximum-length (2^AW word) frame. Tracks J1_LOADER_CSUM_EN like the RTL.
module tb_j1_loader;
  import j1_loader_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          resetq = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          reload = 1'b0;
  logic          in_ready;
  logic          code_wr;
  logic [AW-1:0] code_waddr;
  logic [15:0]   code_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          err;
  state_t        dbg_state;

  int checks   = 0;
  int failures = 0;

  j1_loader #(.AW(AW), .MAGIC(8'hA5)) dut (
    .clk(clk), .resetq(resetq),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload),
    .code_wr(code_wr), .code_waddr(code_waddr), .code_wdata(code_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // One row = inputs for one cycle and the outputs expected just after that clock edge.
  // Address/data are only compared on rows that expect a write strobe.
  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        rl;
    logic        wr;
    logic [11:0] wa;
    logic [15:0] wd;
    logic        cr;
    logic        er;
    logic        bz;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic rl,
                              input logic wr, input logic [11:0] wa, input logic [15:0] wd,
                              input logic cr, input logic er, input logic bz, input logic rdy);
    vec_t t;
    t.d = d; t.v = v; t.rl = rl; t.wr = wr; t.wa = wa; t.wd = wd;
    t.cr = cr; t.er = er; t.bz = bz; t.rdy = rdy;
    return t;
  endfunction

  function automatic vec_t row_busy(input logic [7:0] d);
    return mk(d, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic vec_t row_idle(input logic [7:0] d, input logic v, input logic rl);
    return mk(d, v, rl, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t row_run(input logic [7:0] d, input logic v, input logic rl);
    return mk(d, v, rl, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t row_err(input logic [7:0] d);
    return mk(d, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1);
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic rl);
    in_data  = d;
    in_valid = v;
    reload   = rl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check(name, 64'({code_wr, code_waddr, code_wdata, cpu_reset, err, busy}),
                64'({1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic build_table();
    // Frame A: two words. Good checksum = -(02+00+34+12+CD+AB) mod 256 = -(C0) = 40.
    tbl.push_back(row_busy(8'hA5));
    tbl.push_back(row_busy(8'h02));
    tbl.push_back(row_busy(8'h00));
    tbl.push_back(row_busy(8'h34));
    tbl.push_back(mk(8'h12, 1, 0, 1, 12'h000, 16'h1234, 1, 0, 1, 1));
    tbl.push_back(row_busy(8'hCD));
`ifdef J1_LOADER_CSUM_EN
    tbl.push_back(mk(8'hAB, 1, 0, 1, 12'h001, 16'hABCD, 1, 0, 1, 1));
    tbl.push_back(row_run(8'h40, 1, 0));
`else
    tbl.push_back(mk(8'hAB, 1, 0, 1, 12'h001, 16'hABCD, 0, 0, 0, 0));
`endif
    tbl.push_back(row_run(8'hA5, 1, 0));       // stream ignored in RUN
    tbl.push_back(row_idle(8'hA5, 1, 1));      // reload wins, MAGIC not taken
    tbl.push_back(row_idle(8'h55, 1, 0));      // non-MAGIC dropped
    tbl.push_back(row_idle(8'hA5, 0, 0));      // no valid, nothing moves
    // Empty frame N=0
    tbl.push_back(row_busy(8'hA5));
    tbl.push_back(row_busy(8'h00));
`ifdef J1_LOADER_CSUM_EN
    tbl.push_back(row_busy(8'h00));
    tbl.push_back(row_run(8'h00, 1, 0));
`else
    tbl.push_back(row_run(8'h00, 1, 0));
`endif
    tbl.push_back(row_idle(8'h00, 0, 1));
`ifdef J1_LOADER_CSUM_EN
    // Frame A with checksum off by one: both words still written, then ERR.
    tbl.push_back(row_busy(8'hA5));
    tbl.push_back(row_busy(8'h02));
    tbl.push_back(row_busy(8'h00));
    tbl.push_back(row_busy(8'h34));
    tbl.push_back(mk(8'h12, 1, 0, 1, 12'h000, 16'h1234, 1, 0, 1, 1));
    tbl.push_back(row_busy(8'hCD));
    tbl.push_back(mk(8'hAB, 1, 0, 1, 12'h001, 16'hABCD, 1, 0, 1, 1));
    tbl.push_back(row_err(8'h41));
    tbl.push_back(row_err(8'h00));
`endif
    // Oversize N=4097
    tbl.push_back(row_busy(8'hA5));
    tbl.push_back(row_busy(8'h01));
    tbl.push_back(row_err(8'h10));
    tbl.push_back(row_err(8'h12));             // ERR acts as IDLE, err held
    tbl.push_back(mk(8'hA5, 1, 1, 0, 12'h0, 16'h0, 1, 0, 1, 1));   // reload ignored, MAGIC clears err
    tbl.push_back(row_busy(8'h01));
    tbl.push_back(row_busy(8'h00));
    tbl.push_back(row_busy(8'hEF));
    tbl.push_back(mk(8'h00, 0, 0, 0, 12'h0, 16'h0, 1, 0, 1, 1));   // stall mid-word
`ifdef J1_LOADER_CSUM_EN
    // csum = -(01+00+EF+BE) = -(AE) = 52
    tbl.push_back(mk(8'hBE, 1, 0, 1, 12'h000, 16'hBEEF, 1, 0, 1, 1));
    tbl.push_back(row_run(8'h52, 1, 0));
`else
    tbl.push_back(mk(8'hBE, 1, 0, 1, 12'h000, 16'hBEEF, 0, 0, 0, 0));
`endif
    tbl.push_back(row_idle(8'h00, 0, 1));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0]  sum;
    logic [15:0] w;

    #2;
    check_reset_values("reset_values");
    @(negedge clk);
    resetq = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'({in_ready, cpu_reset}), 64'({1'b1, 1'b1}));

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].rl);
      check($sformatf("row_%0d", i),
            64'({code_wr, (tbl[i].wr ? code_waddr : 12'h000), (tbl[i].wr ? code_wdata : 16'h0000),
                 cpu_reset, err, busy, in_ready}),
            64'({tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].cr, tbl[i].er, tbl[i].bz, tbl[i].rdy}));
    end

    // Asynchronous reset after the first word of a two-word frame.
    drive(8'hA5, 1, 0);
    drive(8'h02, 1, 0);
    drive(8'h00, 1, 0);
    drive(8'h11, 1, 0);
    drive(8'h22, 1, 0);
    check("mf_write0", 64'({code_wr, code_waddr, code_wdata}), 64'({1'b1, 12'h000, 16'h2211}));
    drive(8'h33, 1, 0);
    #2;
    resetq = 1'b0;
    #1;
    check_reset_values("mf_async_reset");
    drive(8'h44, 1, 0);
    check("mf_no_write_in_reset", 64'({code_wr, busy}), 64'({1'b0, 1'b0}));
    #2;
    resetq = 1'b1;
    drive(8'h44, 1, 0);
    check("mf_hi_dropped", 64'({code_wr, busy, err}), 64'({1'b0, 1'b0, 1'b0}));
    drive(8'hA5, 1, 0);
    drive(8'h01, 1, 0);
    drive(8'h00, 1, 0);
    drive(8'h33, 1, 0);
    drive(8'h44, 1, 0);
    check("mf_restart_addr0", 64'({code_wr, code_waddr, code_wdata}), 64'({1'b1, 12'h000, 16'h4433}));
`ifdef J1_LOADER_CSUM_EN
    drive(8'h88, 1, 0);                        // -(01+00+33+44) = -(78) = 88
`endif
    check("mf_run", 64'({cpu_reset, err, busy, in_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b0}));
    drive(8'h00, 0, 1);
    check("mf_reload", 64'({cpu_reset, in_ready}), 64'({1'b1, 1'b1}));

    // Largest legal frame: N = 2^AW words, word i carries value i.
    drive(8'hA5, 1, 0);
    drive(8'h00, 1, 0);
    drive(8'h10, 1, 0);
    check("max_len_accepted", 64'({busy, err}), 64'({1'b1, 1'b0}));
    sum = 8'h10;
    for (int i = 0; i < (1 << AW); i++) begin
      w = 16'(i);
      drive(w[7:0], 1, 0);
      drive(w[15:8], 1, 0);
      sum = sum + w[7:0] + w[15:8];
      check($sformatf("max_write_%0d", i), 64'({code_wr, code_waddr, code_wdata}),
            64'({1'b1, w[11:0], w}));
    end
`ifdef J1_LOADER_CSUM_EN
    drive(8'h00 - sum, 1, 0);
`endif
    check("max_len_run", 64'({cpu_reset, err, busy, in_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b0}));
    drive(8'h00, 0, 1);
    check("max_len_reload", 64'({cpu_reset, busy, in_ready}), 64'({1'b1, 1'b0, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
